// File: rtl/tlp_mux.sv
// Packet-atomic round-robin merge of the read-side and write-side TLP streams
// onto one transmit port, fully registered through a two-entry skid buffer.
module tlp_mux #(
  parameter int DOUBLE_WORD  = 32,
  parameter int HEADER_SIZE  = 4*DOUBLE_WORD,
  parameter int PAYLOAD_SIZE = 8*DOUBLE_WORD
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PAYLOAD_SIZE-1:0] r_in_data,
  input  logic [HEADER_SIZE-1:0]  r_in_hdr,
  input  logic                    r_in_sop,
  input  logic                    r_in_eop,
  input  logic                    r_in_valid,
  output logic                    r_in_ready,
  input  logic [PAYLOAD_SIZE-1:0] w_in_data,
  input  logic [HEADER_SIZE-1:0]  w_in_hdr,
  input  logic                    w_in_sop,
  input  logic                    w_in_eop,
  input  logic                    w_in_valid,
  output logic                    w_in_ready,
  output logic [PAYLOAD_SIZE-1:0] out_data,
  output logic [HEADER_SIZE-1:0]  out_hdr,
  output logic                    out_sop,
  output logic                    out_eop,
  output logic                    out_valid,
  input  logic                    out_ready,
  input  logic                    enable,
  output logic                    drop
);

  typedef enum logic [1:0] {IDLE, LOCK_R, LOCK_W} state_t;

  state_t state, state_next;
  logic   last_grant, last_grant_next;  // 1 = write side granted last
  logic   sel_r, sel_w, r_stray, w_stray;
  logic   r_acc, w_acc, beat_accept;
  logic   in_ready_int, in_ready_early;

  logic [PAYLOAD_SIZE-1:0] beat_data;
  logic [HEADER_SIZE-1:0]  beat_hdr, sel_hdr, hdr_reg;
  logic                    beat_sop, beat_eop;

  logic [PAYLOAD_SIZE-1:0] tmp_data;
  logic [HEADER_SIZE-1:0]  tmp_hdr;
  logic                    tmp_sop, tmp_eop, tmp_valid;
  logic                    out_valid_next, tmp_valid_next;
  logic                    store_in_to_out, store_in_to_tmp, store_tmp_to_out;

  // Stray beats get ready too (only in IDLE) so they can be discarded.
  assign r_in_ready = in_ready_int & (sel_r | r_stray);
  assign w_in_ready = in_ready_int & (sel_w | w_stray);

  always_comb begin
    sel_r           = 1'b0;
    sel_w           = 1'b0;
    r_stray         = 1'b0;
    w_stray         = 1'b0;
    state_next      = state;
    last_grant_next = last_grant;
    case (state)
      IDLE: begin
        r_stray = r_in_valid & ~r_in_sop;
        w_stray = w_in_valid & ~w_in_sop;
        if (enable) begin
          if ((r_in_valid & r_in_sop) && (w_in_valid & w_in_sop)) begin
            sel_r = last_grant;
            sel_w = ~last_grant;
          end else begin
            sel_r = r_in_valid & r_in_sop;
            sel_w = w_in_valid & w_in_sop;
          end
        end
      end
      LOCK_R:  sel_r = 1'b1;
      LOCK_W:  sel_w = 1'b1;
      default: state_next = IDLE;
    endcase

    r_acc       = sel_r & r_in_valid & in_ready_int;
    w_acc       = sel_w & w_in_valid & in_ready_int;
    beat_accept = r_acc | w_acc;

    beat_data = sel_w ? w_in_data : r_in_data;
    sel_hdr   = sel_w ? w_in_hdr  : r_in_hdr;
    beat_sop  = sel_w ? w_in_sop  : r_in_sop;
    beat_eop  = sel_w ? w_in_eop  : r_in_eop;
    beat_hdr  = (state == IDLE) ? sel_hdr : hdr_reg;

    if (state == IDLE) begin
      if (r_acc) begin
        last_grant_next = 1'b0;
        if (!r_in_eop) state_next = LOCK_R;
      end else if (w_acc) begin
        last_grant_next = 1'b1;
        if (!w_in_eop) state_next = LOCK_W;
      end
    end else if (beat_accept && beat_eop) begin
      state_next = IDLE;
    end
  end

  // Skid control: input ready is registered, so out_ready never reaches the
  // input ready ports combinationally; the temp entry absorbs the one beat
  // that can arrive after downstream stalls.
  always_comb begin
    out_valid_next   = out_valid;
    tmp_valid_next   = tmp_valid;
    store_in_to_out  = 1'b0;
    store_in_to_tmp  = 1'b0;
    store_tmp_to_out = 1'b0;
    if (in_ready_int) begin
      if (out_ready || !out_valid) begin
        out_valid_next  = beat_accept;
        store_in_to_out = 1'b1;
      end else begin
        tmp_valid_next  = beat_accept;
        store_in_to_tmp = 1'b1;
      end
    end else if (out_ready) begin
      out_valid_next   = tmp_valid;
      tmp_valid_next   = 1'b0;
      store_tmp_to_out = 1'b1;
    end
    in_ready_early = out_ready | (~tmp_valid & (~out_valid | ~beat_accept));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      hdr_reg    <= '0;
      drop       <= 1'b0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      drop       <= in_ready_int & (r_stray | w_stray);
      if (beat_accept && state == IDLE) hdr_reg <= sel_hdr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_int <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_hdr      <= '0;
      out_sop      <= 1'b0;
      out_eop      <= 1'b0;
      tmp_valid    <= 1'b0;
      tmp_data     <= '0;
      tmp_hdr      <= '0;
      tmp_sop      <= 1'b0;
      tmp_eop      <= 1'b0;
    end else begin
      in_ready_int <= in_ready_early;
      out_valid    <= out_valid_next;
      tmp_valid    <= tmp_valid_next;
      if (store_in_to_out) begin
        out_data <= beat_data;
        out_hdr  <= beat_hdr;
        out_sop  <= beat_sop;
        out_eop  <= beat_eop;
      end else if (store_tmp_to_out) begin
        out_data <= tmp_data;
        out_hdr  <= tmp_hdr;
        out_sop  <= tmp_sop;
        out_eop  <= tmp_eop;
      end
      if (store_in_to_tmp) begin
        tmp_data <= beat_data;
        tmp_hdr  <= beat_hdr;
        tmp_sop  <= beat_sop;
        tmp_eop  <= beat_eop;
      end
    end
  end

endmodule

// File: tb/tb_tlp_mux.sv
// Directed self-checking bench for tlp_mux: arbitration, stalls, stray-beat
// discard, enable gating and mid-packet reset.
module tb_tlp_mux;
  localparam int HS = 128;
  localparam int PS = 256;
  localparam int BW = HS + PS + 2;

  logic clk = 1'b0;
  logic rst;
  logic [PS-1:0] r_in_data, w_in_data, out_data;
  logic [HS-1:0] r_in_hdr, w_in_hdr, out_hdr;
  logic r_in_sop, r_in_eop, r_in_valid, r_in_ready;
  logic w_in_sop, w_in_eop, w_in_valid, w_in_ready;
  logic out_sop, out_eop, out_valid, out_ready, enable, drop;

  always #5 clk = ~clk;

  tlp_mux dut (
    .clk(clk), .rst(rst),
    .r_in_data(r_in_data), .r_in_hdr(r_in_hdr), .r_in_sop(r_in_sop),
    .r_in_eop(r_in_eop), .r_in_valid(r_in_valid), .r_in_ready(r_in_ready),
    .w_in_data(w_in_data), .w_in_hdr(w_in_hdr), .w_in_sop(w_in_sop),
    .w_in_eop(w_in_eop), .w_in_valid(w_in_valid), .w_in_ready(w_in_ready),
    .out_data(out_data), .out_hdr(out_hdr), .out_sop(out_sop),
    .out_eop(out_eop), .out_valid(out_valid), .out_ready(out_ready),
    .enable(enable), .drop(drop)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int drop_cnt = 0;
  logic [BW-1:0] got[$];
  int got_cyc[$];
  logic [BW-1:0] cur, prev_beat;
  logic prev_stall = 1'b0;
  bit watch_r = 1'b0;
  bit r_ready_seen = 1'b0;

  assign cur = {out_hdr, out_data, out_sop, out_eop};

  task automatic check_output(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BW-1:0] mk(input logic [HS-1:0] h, input logic [PS-1:0] d,
                                       input logic s, input logic e);
    return {h, d, s, e};
  endfunction

  function automatic logic [BW-1:0] beat_at(input int i);
    if (i < got.size()) return got[i];
    return 'x;
  endfunction

  function automatic int cyc_at(input int i);
    if (i < got_cyc.size()) return got_cyc[i];
    return -1;
  endfunction

  // Output monitor: records transfers, counts drop pulses, checks stall stability.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst) begin
      if (out_valid && out_ready) begin
        got.push_back(cur);
        got_cyc.push_back(cyc);
      end
      if (drop) drop_cnt++;
      if (prev_stall) check_output("stall_hold", cur, prev_beat);
      if (watch_r && r_in_ready) r_ready_seen = 1'b1;
    end
    prev_stall = !rst && out_valid && !out_ready;
    prev_beat  = cur;
  end

  task automatic idle_port(input bit port);
    if (port) begin
      w_in_valid = 0; w_in_sop = 0; w_in_eop = 0;
    end else begin
      r_in_valid = 0; r_in_sop = 0; r_in_eop = 0;
    end
  endtask

  // Called at a negedge; returns at the negedge following the accepting posedge.
  task automatic send_beat(input bit port, input logic [HS-1:0] h, input logic [PS-1:0] d,
                           input logic s, input logic e, output int acc_cyc);
    int n;
    logic acc;
    n = 0;
    acc = 1'b0;
    if (port) begin
      w_in_valid = 1; w_in_hdr = h; w_in_data = d; w_in_sop = s; w_in_eop = e;
    end else begin
      r_in_valid = 1; r_in_hdr = h; r_in_data = d; r_in_sop = s; r_in_eop = e;
    end
    while (!acc && n < 64) begin
      #1;
      acc = port ? w_in_ready : r_in_ready;
      @(negedge clk);
      n++;
    end
    acc_cyc = cyc;
    check_output(port ? "w_accept" : "r_accept", acc, 1);
  endtask

  task automatic apply_stimulus(input bit port, input logic [HS-1:0] h, input logic [PS-1:0] base,
                                input int nbeats, output int first_cyc);
    int c;
    first_cyc = -1;
    for (int i = 0; i < nbeats; i++) begin
      send_beat(port, h, base + PS'(i), i == 0, i == nbeats - 1, c);
      if (i == 0) first_cyc = c;
    end
    idle_port(port);
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    idle_port(0);
    idle_port(1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic drain();
    repeat (8) @(negedge clk);
  endtask

  task automatic clear_log();
    got.delete();
    got_cyc.delete();
  endtask

  logic [11:0] pat;
  int c0, c1;

  initial begin
    r_in_data = '0; r_in_hdr = '0; w_in_data = '0; w_in_hdr = '0;
    idle_port(0);
    idle_port(1);
    out_ready = 1'b1;
    enable = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_output("rst_out_valid", out_valid, 0);
    check_output("rst_out_beat", cur, '0);
    check_output("rst_r_ready", r_in_ready, 0);
    check_output("rst_w_ready", w_in_ready, 0);
    check_output("rst_drop", drop, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // R 3-beat packet with out_ready high
    clear_log();
    drop_cnt = 0;
    apply_stimulus(0, 128'h40000001, 256'h1, 3, c0);
    drain();
    check_output("p1_count", got.size(), 3);
    check_output("p1_b0", beat_at(0), mk(128'h40000001, 256'h1, 1, 0));
    check_output("p1_b1", beat_at(1), mk(128'h40000001, 256'h2, 0, 0));
    check_output("p1_b2", beat_at(2), mk(128'h40000001, 256'h3, 0, 1));
    check_output("p1_latency", cyc_at(0), c0 + 1);
    check_output("p1_thruput", cyc_at(2), c0 + 3);
    check_output("p1_no_drop", drop_cnt, 0);

    // Tie after reset: R first, then W
    reset_dut();
    clear_log();
    fork
      apply_stimulus(0, 128'h40000010, 256'h10, 2, c0);
      apply_stimulus(1, 128'h60000020, 256'h20, 2, c1);
    join
    drain();
    check_output("tieA_count", got.size(), 4);
    check_output("tieA_b0", beat_at(0), mk(128'h40000010, 256'h10, 1, 0));
    check_output("tieA_b1", beat_at(1), mk(128'h40000010, 256'h11, 0, 1));
    check_output("tieA_b2", beat_at(2), mk(128'h60000020, 256'h20, 1, 0));
    check_output("tieA_b3", beat_at(3), mk(128'h60000020, 256'h21, 0, 1));

    // R alone (single beat) so R was granted last; the next tie goes to W
    clear_log();
    apply_stimulus(0, 128'h40000080, 256'h80, 1, c0);
    fork
      apply_stimulus(0, 128'h40000011, 256'h15, 1, c0);
      apply_stimulus(1, 128'h60000021, 256'h25, 2, c1);
    join
    drain();
    check_output("tieB_count", got.size(), 4);
    check_output("tieB_single", beat_at(0), mk(128'h40000080, 256'h80, 1, 1));
    check_output("tieB_b1", beat_at(1), mk(128'h60000021, 256'h25, 1, 0));
    check_output("tieB_b2", beat_at(2), mk(128'h60000021, 256'h26, 0, 1));
    check_output("tieB_b3", beat_at(3), mk(128'h40000011, 256'h15, 1, 1));

    // W 4-beat packet under toggling backpressure
    clear_log();
    r_ready_seen = 1'b0;
    watch_r = 1'b1;
    pat = 12'b1001_0100_1101;
    fork
      apply_stimulus(1, 128'h60000030, 256'h30, 4, c1);
      for (int i = 0; i < 12; i++) begin
        out_ready = pat[11-i];
        @(negedge clk);
      end
    join
    out_ready = 1'b1;
    drain();
    watch_r = 1'b0;
    check_output("stall_count", got.size(), 4);
    check_output("stall_b0", beat_at(0), mk(128'h60000030, 256'h30, 1, 0));
    check_output("stall_b1", beat_at(1), mk(128'h60000030, 256'h31, 0, 0));
    check_output("stall_b2", beat_at(2), mk(128'h60000030, 256'h32, 0, 0));
    check_output("stall_b3", beat_at(3), mk(128'h60000030, 256'h33, 0, 1));
    check_output("stall_r_ready", r_ready_seen, 0);

    // Stray R beat in IDLE is discarded
    clear_log();
    drop_cnt = 0;
    r_in_valid = 1; r_in_sop = 0; r_in_eop = 0; r_in_data = 256'hBAD;
    #1;
    check_output("stray_r_ready", r_in_ready, 1);
    @(negedge clk);
    idle_port(0);
    drain();
    check_output("stray_drop_cnt", drop_cnt, 1);
    check_output("stray_not_fwd", got.size(), 0);

    // Both ports stray in the same cycle
    r_in_valid = 1; r_in_sop = 0; w_in_valid = 1; w_in_sop = 0;
    #1;
    check_output("stray2_r_ready", r_in_ready, 1);
    check_output("stray2_w_ready", w_in_ready, 1);
    @(negedge clk);
    idle_port(0);
    idle_port(1);
    drain();
    check_output("stray2_not_fwd", got.size(), 0);

    // Enable dropped mid W packet with R waiting
    clear_log();
    send_beat(1, 128'h60000050, 256'h50, 1, 0, c1);
    enable = 1'b0;
    r_in_valid = 1; r_in_sop = 1; r_in_eop = 1;
    r_in_hdr = 128'h40000060; r_in_data = 256'h60;
    r_ready_seen = 1'b0;
    watch_r = 1'b1;
    send_beat(1, 128'h0, 256'h51, 0, 0, c1);
    send_beat(1, 128'h0, 256'h52, 0, 1, c1);
    idle_port(1);
    repeat (5) @(negedge clk);
    watch_r = 1'b0;
    check_output("en_r_blocked", r_ready_seen, 0);
    check_output("en_w_done", got.size(), 3);
    enable = 1'b1;
    #1;
    check_output("en_r_grant", r_in_ready, 1);
    send_beat(0, 128'h40000060, 256'h60, 1, 1, c0);
    idle_port(0);
    drain();
    check_output("en_b0", beat_at(0), mk(128'h60000050, 256'h50, 1, 0));
    check_output("en_b1", beat_at(1), mk(128'h60000050, 256'h51, 0, 0));
    check_output("en_b2", beat_at(2), mk(128'h60000050, 256'h52, 0, 1));
    check_output("en_b3", beat_at(3), mk(128'h40000060, 256'h60, 1, 1));

    // Reset during beat 2 of an R packet
    send_beat(0, 128'h40000090, 256'h90, 1, 0, c0);
    r_in_data = 256'h91; r_in_sop = 0;
    #1 rst = 1'b1;
    #1;
    check_output("mid_rst_valid", out_valid, 0);
    check_output("mid_rst_beat", cur, '0);
    check_output("mid_rst_r_ready", r_in_ready, 0);
    check_output("mid_rst_drop", drop, 0);
    @(negedge clk);
    idle_port(0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_log();
    apply_stimulus(1, 128'h60000070, 256'h70, 2, c1);
    drain();
    check_output("post_rst_count", got.size(), 2);
    check_output("post_rst_b0", beat_at(0), mk(128'h60000070, 256'h70, 1, 0));
    check_output("post_rst_b1", beat_at(1), mk(128'h60000070, 256'h71, 0, 1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
